// File: rtl/mdu_pkg.sv
// Shared opcode/state types and helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle, XLEN iterations, done pulses once.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_p0;
  logic [XLEN-1:0] quo_p0;
  logic [XLEN-1:0] dvs_p0;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic            last;

  // Borrow out of the XLEN+1 bit subtract tells whether the divisor fits;
  // the shifted partial remainder is always below twice the divisor.
  assign shifted = {rem_p0, quo_p0[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_p0};
  assign ge      = ~diff[XLEN];
  assign last    = (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      busy <= ~last;
      done <= last;
      cnt  <= cnt + 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
      dvs_p0 <= divisor;
    end else if (busy) begin
      rem_p0 <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_p0 <= {quo_p0[XLEN-2:0], ge};
    end
  end

  assign quotient  = quo_p0;
  assign remainder = rem_p0;

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake and flush.
// Define MDU_DIV_EN to build the iterative divider; otherwise divides return 0 one cycle after accept.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int MCW = $clog2(MUL_LAT + 1);

  mdu_state_e      state, state_nxt;
  mdu_op_e         op_in, op_p0;
  logic [XLEN-1:0] src1_p0, src2_p0;
  logic [MCW-1:0]  mul_cnt;
  logic            accept;
  logic            load_res;
  logic [XLEN-1:0] res_val;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] div_res;
  logic            div_ready;

  logic signed [2*XLEN-1:0] mul_a, mul_b, product;

  assign op_in      = mdu_op_e'(req_op);
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign accept     = req_valid & req_ready & ~flush;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= op_in;
      src1_p0 <= req_src1;
      src2_p0 <= req_src2;
    end
  end

  // Product is a multi-cycle path from the operand latch, captured after MUL_LAT cycles.
  assign mul_a   = {{XLEN{((op_p0 == OP_MULH) || (op_p0 == OP_MULHSU)) & src1_p0[XLEN-1]}}, src1_p0};
  assign mul_b   = {{XLEN{(op_p0 == OP_MULH) & src2_p0[XLEN-1]}}, src2_p0};
  assign product = mul_a * mul_b;
  assign mul_res = (op_p0 == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            sdiv_in, zero_in, ovf_in, special_in, div_start;
  logic [XLEN-1:0] mag1_in, mag2_in;
  logic            special_p0, zero_p0, neg_q_p0, neg_r_p0;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem, q_fix, r_fix, spec_q, spec_r;

  assign sdiv_in    = is_signed_div(op_in);
  assign mag1_in    = (sdiv_in & req_src1[XLEN-1]) ? -req_src1 : req_src1;
  assign mag2_in    = (sdiv_in & req_src2[XLEN-1]) ? -req_src2 : req_src2;
  assign zero_in    = (req_src2 == '0);
  assign ovf_in     = sdiv_in & (req_src1 == MIN) & (req_src2 == '1);
  assign special_in = zero_in | ovf_in;
  assign div_start  = accept & is_div(op_in) & ~special_in;

  always_ff @(posedge clk) begin
    if (accept) begin
      special_p0 <= special_in;
      zero_p0    <= zero_in;
      neg_q_p0   <= sdiv_in & (req_src1[XLEN-1] ^ req_src2[XLEN-1]);
      neg_r_p0   <= sdiv_in & req_src1[XLEN-1];
    end
  end

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .kill      (flush),
    .dividend  (mag1_in),
    .divisor   (mag2_in),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign fixup cycle; special cases resolve from latched flags without iterating.
  assign q_fix     = neg_q_p0 ? -div_quo : div_quo;
  assign r_fix     = neg_r_p0 ? -div_rem : div_rem;
  assign spec_q    = zero_p0 ? '1 : MIN;
  assign spec_r    = zero_p0 ? src1_p0 : '0;
  assign div_res   = special_p0 ? (op_p0[1] ? spec_r : spec_q)
                                : (op_p0[1] ? r_fix : q_fix);
  assign div_ready = special_p0 | (div_done & ~div_busy);
`else
  assign div_res   = '0;
  assign div_ready = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    res_val   = mul_res;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_div(op_in) ? ST_DIV : ST_MUL;
      ST_MUL: begin
        if (mul_cnt == MCW'(MUL_LAT - 1)) begin
          state_nxt = ST_DONE;
          load_res  = 1'b1;
        end
      end
      ST_DIV: begin
        res_val = div_res;
        if (div_ready) begin
          state_nxt = ST_DONE;
          load_res  = 1'b1;
        end
      end
      ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      load_res  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mul_cnt   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_MUL && !flush) mul_cnt <= mul_cnt + 1'b1;
      else                           mul_cnt <= '0;
      if (load_res) resp_data <= res_val;
    end
  end

endmodule
